// File: rtl/sig_dly_meas.sv
// sig_dly_meas: measures the start->stop pulse interval in whole microseconds.
// Optional min/max statistics are enabled with `define SIG_DLY_MEAS_STAT_EN.
module sig_dly_meas #(
  parameter int unsigned CNT_1US = 50,
  parameter int unsigned W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sig_start,
  input  logic         sig_stop,
`ifdef SIG_DLY_MEAS_STAT_EN
  input  logic         stat_clr,
  output logic [W-1:0] dly_min,
  output logic [W-1:0] dly_max,
`endif
  output logic         busy,
  output logic [W-1:0] dly_out,
  output logic         dly_vld,
  output logic         dly_ovf
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam logic [5:0]   DIV_LAST = 6'(CNT_1US - 1);
  localparam logic [W-1:0] US_MAX   = '1;
  localparam logic [W-1:0] US_ONE   = {{(W-1){1'b0}}, 1'b1};

  state_e       state_q;
  logic [5:0]   cnt_div_q, cnt_div_d;
  logic [W-1:0] cnt_us_q, cnt_us_d;
  logic         ovf_q, ovf_d;
  logic         wrap;
  logic         busy_q;
  logic [W-1:0] dly_out_q;
  logic         dly_vld_q;
  logic         dly_ovf_q;

  // Next counter values; the divider is loaded with 0 at start so that
  // the value seen at edge t0+E is (E-1) mod CNT_1US and a wrap on the
  // stop edge itself completes the k-th microsecond at E = k*CNT_1US.
  always_comb begin
    wrap      = (cnt_div_q == DIV_LAST);
    cnt_div_d = wrap ? 6'd0 : cnt_div_q + 6'd1;
    cnt_us_d  = cnt_us_q;
    ovf_d     = ovf_q;
    if (wrap) begin
      if (cnt_us_q == US_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_us_d = cnt_us_q + US_ONE;
      end
    end
  end

  // Measurement FSM with registered outputs; stop beats start in RUN,
  // start beats stop in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_div_q <= '0;
      cnt_us_q  <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      dly_out_q <= '0;
      dly_vld_q <= 1'b0;
      dly_ovf_q <= 1'b0;
    end else begin
      dly_vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sig_start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            cnt_div_q <= '0;
            cnt_us_q  <= '0;
            ovf_q     <= 1'b0;
          end
        end
        RUN: begin
          if (sig_stop) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            dly_out_q <= cnt_us_d;
            dly_ovf_q <= ovf_d;
            dly_vld_q <= 1'b1;
          end else if (sig_start) begin
            cnt_div_q <= '0;
            cnt_us_q  <= '0;
            ovf_q     <= 1'b0;
          end else begin
            cnt_div_q <= cnt_div_d;
            cnt_us_q  <= cnt_us_d;
            ovf_q     <= ovf_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign dly_out = dly_out_q;
  assign dly_vld = dly_vld_q;
  assign dly_ovf = dly_ovf_q;

`ifdef SIG_DLY_MEAS_STAT_EN
  logic [W-1:0] min_q;
  logic [W-1:0] max_q;

  // Running min/max of published results; clear overrides a pending update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= US_MAX;
      max_q <= '0;
    end else if (stat_clr) begin
      min_q <= US_MAX;
      max_q <= '0;
    end else if (dly_vld_q) begin
      if (dly_out_q < min_q) min_q <= dly_out_q;
      if (dly_out_q > max_q) max_q <= dly_out_q;
    end
  end

  assign dly_min = min_q;
  assign dly_max = max_q;
`endif

endmodule

// File: tb/tb_sig_dly_meas.sv
// tb_sig_dly_meas: directed checks of sig_dly_meas at W=16 and W=4.
// Drives on negedges, samples on negedges (between active edges).
module tb_sig_dly_meas;

  logic        clk;
  logic        rst_n;
  logic        sig_start;
  logic        sig_stop;
  logic        busy, dly_vld, dly_ovf;
  logic [15:0] dly_out;
  logic        busy4, vld4, ovf4;
  logic [3:0]  out4;
`ifdef SIG_DLY_MEAS_STAT_EN
  logic        stat_clr;
  logic [15:0] dmin, dmax;
  logic [3:0]  dmin4, dmax4;
`endif

  int n_vec = 0;
  int n_err = 0;
  int vld_total = 0;

  sig_dly_meas #(.CNT_1US(50), .W(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .sig_start(sig_start), .sig_stop(sig_stop),
`ifdef SIG_DLY_MEAS_STAT_EN
    .stat_clr(stat_clr), .dly_min(dmin), .dly_max(dmax),
`endif
    .busy(busy), .dly_out(dly_out),
    .dly_vld(dly_vld), .dly_ovf(dly_ovf)
  );

  sig_dly_meas #(.CNT_1US(50), .W(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .sig_start(sig_start), .sig_stop(sig_stop),
`ifdef SIG_DLY_MEAS_STAT_EN
    .stat_clr(stat_clr), .dly_min(dmin4), .dly_max(dmax4),
`endif
    .busy(busy4), .dly_out(out4),
    .dly_vld(vld4), .dly_ovf(ovf4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (dly_vld) vld_total <= vld_total + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one-cycle pulse sampled on the next posedge; returns one negedge later
  task automatic drv(input logic s, input logic p);
    sig_start = s;
    sig_stop  = p;
    @(negedge clk);
    sig_start = 1'b0;
    sig_stop  = 1'b0;
  endtask

  task automatic test_reset;
    idle(2);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0d want 0", busy); end
    n_vec++; if (dly_out !== 16'd0) begin n_err++; $display("FAIL rst_out: got %0d want 0", dly_out); end
    n_vec++; if (dly_vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %0d want 0", dly_vld); end
    n_vec++; if (dly_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %0d want 0", dly_ovf); end
`ifdef SIG_DLY_MEAS_STAT_EN
    n_vec++; if (dmin !== 16'hFFFF) begin n_err++; $display("FAIL rst_min: got %0d want 65535", dmin); end
    n_vec++; if (dmax !== 16'd0) begin n_err++; $display("FAIL rst_max: got %0d want 0", dmax); end
`endif
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic;
    bit busy_ok;
    int n0;
    busy_ok = 1'b1;
    n0 = vld_total;
    drv(1'b1, 1'b0);
    repeat (499) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    drv(1'b0, 1'b1);
    n_vec++; if (!busy_ok) begin n_err++; $display("FAIL basic_busy_run: got 0 want 1"); end
    n_vec++; if (dly_vld !== 1'b1) begin n_err++; $display("FAIL basic_vld: got %0d want 1", dly_vld); end
    n_vec++; if (dly_out !== 16'd10) begin n_err++; $display("FAIL basic_out: got %0d want 10", dly_out); end
    n_vec++; if (dly_ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %0d want 0", dly_ovf); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %0d want 0", busy); end
    idle(1);
    n_vec++; if (dly_vld !== 1'b0) begin n_err++; $display("FAIL basic_vld_one: got %0d want 0", dly_vld); end
    n_vec++; if (vld_total - n0 !== 1) begin n_err++; $display("FAIL basic_vld_cnt: got %0d want 1", vld_total - n0); end
    n_vec++; if (dly_out !== 16'd10) begin n_err++; $display("FAIL basic_hold: got %0d want 10", dly_out); end
  endtask

  task automatic test_boundary;
    int e_tab[7]   = '{1, 49, 50, 99, 100, 549, 550};
    int exp_tab[7] = '{0, 0, 1, 1, 2, 10, 11};
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, 1'b0);
      idle(e_tab[i] - 1);
      drv(1'b0, 1'b1);
      n_vec++; if (dly_vld !== 1'b1) begin n_err++; $display("FAIL bnd_vld E=%0d: got %0d want 1", e_tab[i], dly_vld); end
      n_vec++; if (dly_out !== 16'(exp_tab[i])) begin n_err++; $display("FAIL bnd_out E=%0d: got %0d want %0d", e_tab[i], dly_out, exp_tab[i]); end
      n_vec++; if (out4 !== 4'(exp_tab[i])) begin n_err++; $display("FAIL bnd_out4 E=%0d: got %0d want %0d", e_tab[i], out4, exp_tab[i]); end
      idle(1);
    end
  endtask

  task automatic test_restart;
    int n0;
    n0 = vld_total;
    drv(1'b1, 1'b0);
    idle(199);
    drv(1'b1, 1'b0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_run_busy: got %0d want 1", busy); end
    idle(299);
    drv(1'b0, 1'b1);
    n_vec++; if (dly_out !== 16'd6) begin n_err++; $display("FAIL restart_out: got %0d want 6", dly_out); end
    idle(1);
    n_vec++; if (vld_total - n0 !== 1) begin n_err++; $display("FAIL restart_vld_cnt: got %0d want 1", vld_total - n0); end
  endtask

  task automatic test_control;
    int n0;
    n0 = vld_total;
    drv(1'b0, 1'b1);
    idle(3);
    n_vec++; if (vld_total - n0 !== 0) begin n_err++; $display("FAIL idle_stop_vld: got %0d want 0", vld_total - n0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_stop_busy: got %0d want 0", busy); end
    drv(1'b1, 1'b1);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL idle_both_busy: got %0d want 1", busy); end
    n_vec++; if (dly_vld !== 1'b0) begin n_err++; $display("FAIL idle_both_vld: got %0d want 0", dly_vld); end
    idle(99);
    drv(1'b0, 1'b1);
    n_vec++; if (dly_out !== 16'd2) begin n_err++; $display("FAIL idle_both_out: got %0d want 2", dly_out); end
    idle(2);
    drv(1'b1, 1'b0);
    idle(74);
    drv(1'b1, 1'b1);
    n_vec++; if (dly_vld !== 1'b1) begin n_err++; $display("FAIL run_both_vld: got %0d want 1", dly_vld); end
    n_vec++; if (dly_out !== 16'd1) begin n_err++; $display("FAIL run_both_out: got %0d want 1", dly_out); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_both_busy: got %0d want 0", busy); end
    idle(1);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL run_both_idle: got %0d want 0", busy); end
  endtask

  task automatic test_saturation;
    drv(1'b1, 1'b0);
    idle(999);
    drv(1'b0, 1'b1);
    n_vec++; if (out4 !== 4'd15) begin n_err++; $display("FAIL sat_out4: got %0d want 15", out4); end
    n_vec++; if (ovf4 !== 1'b1) begin n_err++; $display("FAIL sat_ovf4: got %0d want 1", ovf4); end
    n_vec++; if (dly_out !== 16'd20) begin n_err++; $display("FAIL sat_out16: got %0d want 20", dly_out); end
    n_vec++; if (dly_ovf !== 1'b0) begin n_err++; $display("FAIL sat_ovf16: got %0d want 0", dly_ovf); end
    idle(5);
    drv(1'b1, 1'b0);
    n_vec++; if (ovf4 !== 1'b1) begin n_err++; $display("FAIL sat_ovf4_hold: got %0d want 1", ovf4); end
    idle(149);
    drv(1'b0, 1'b1);
    n_vec++; if (out4 !== 4'd3) begin n_err++; $display("FAIL sat_next_out4: got %0d want 3", out4); end
    n_vec++; if (ovf4 !== 1'b0) begin n_err++; $display("FAIL sat_next_ovf4: got %0d want 0", ovf4); end
    idle(1);
  endtask

  task automatic test_async_reset;
    int n0;
    drv(1'b1, 1'b0);
    idle(249);
    n0 = vld_total;
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %0d want 0", busy); end
    n_vec++; if (dly_out !== 16'd0) begin n_err++; $display("FAIL arst_out: got %0d want 0", dly_out); end
    n_vec++; if (out4 !== 4'd0) begin n_err++; $display("FAIL arst_out4: got %0d want 0", out4); end
    n_vec++; if (dly_ovf !== 1'b0) begin n_err++; $display("FAIL arst_ovf: got %0d want 0", dly_ovf); end
    idle(2);
    rst_n = 1'b1;
    idle(1);
    drv(1'b0, 1'b1);
    idle(2);
    n_vec++; if (vld_total - n0 !== 0) begin n_err++; $display("FAIL arst_vld_cnt: got %0d want 0", vld_total - n0); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL arst_stop_busy: got %0d want 0", busy); end
  endtask

`ifdef SIG_DLY_MEAS_STAT_EN
  task automatic test_stats;
    int e_tab[3] = '{350, 150, 450};
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b0);
      idle(e_tab[i] - 1);
      drv(1'b0, 1'b1);
      idle(1);
    end
    n_vec++; if (dmin !== 16'd3) begin n_err++; $display("FAIL stat_min: got %0d want 3", dmin); end
    n_vec++; if (dmax !== 16'd9) begin n_err++; $display("FAIL stat_max: got %0d want 9", dmax); end
    n_vec++; if (dmin4 !== 4'd3) begin n_err++; $display("FAIL stat_min4: got %0d want 3", dmin4); end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    n_vec++; if (dmin !== 16'hFFFF) begin n_err++; $display("FAIL stat_clr_min: got %0d want 65535", dmin); end
    n_vec++; if (dmax !== 16'd0) begin n_err++; $display("FAIL stat_clr_max: got %0d want 0", dmax); end
    n_vec++; if (dmin4 !== 4'hF) begin n_err++; $display("FAIL stat_clr_min4: got %0d want 15", dmin4); end
    drv(1'b1, 1'b0);
    idle(249);
    drv(1'b0, 1'b1);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    n_vec++; if (dmax !== 16'd0) begin n_err++; $display("FAIL stat_clr_wins: got %0d want 0", dmax); end
    idle(1);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    sig_start = 1'b0;
    sig_stop  = 1'b0;
`ifdef SIG_DLY_MEAS_STAT_EN
    stat_clr  = 1'b0;
`endif
    test_reset();
    test_basic();
    test_boundary();
    test_restart();
    test_control();
    test_saturation();
    test_async_reset();
`ifdef SIG_DLY_MEAS_STAT_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
